// File: rtl/axil_reg_bank.sv
// AXI-Lite responder exposing REG_COUNT read/write registers with byte strobes.
// Write and read channels run independently; out-of-range accesses return SLVERR.
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int REG_COUNT = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  output logic [REG_COUNT-1:0]            reg_wr
);

  localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - ADDR_LSB;

  logic                  aw_held, w_held;
  logic [IDX_WIDTH-1:0]  aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  aw_ok, ar_ok;
  logic                  aw_held_nxt, w_held_nxt, rvalid_nxt;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [REG_COUNT-1:0]  wr_sel;

  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

  function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
    return 32'(idx) < 32'(REG_COUNT);
  endfunction

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = aw_held && w_held && (!s_axil_bvalid || s_axil_bready);
  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_ok  = in_range(aw_idx);
  assign ar_ok  = in_range(ar_idx);

  // Readies are registered copies of the next-cycle hold/valid state, so they
  // drop in the same cycle the hold fills and rise the cycle after it empties.
  assign aw_held_nxt = commit ? 1'b0 : (aw_held || aw_hs);
  assign w_held_nxt  = commit ? 1'b0 : (w_held || w_hs);
  assign rvalid_nxt  = ar_hs || (s_axil_rvalid && !s_axil_rready);

  always_comb begin
    rd_word = '0;
    wr_sel  = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (ar_idx == IDX_WIDTH'(i)) rd_word = regs[i];
      wr_sel[i] = commit && aw_ok && (aw_idx == IDX_WIDTH'(i));
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx <= s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    if (w_hs) begin
      w_data <= s_axil_wdata;
      w_strb <= s_axil_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= '0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= '0;
      s_axil_rdata   <= '0;
      reg_wr         <= '0;
    end else begin
      aw_held        <= aw_held_nxt;
      w_held         <= w_held_nxt;
      s_axil_awready <= !aw_held_nxt;
      s_axil_wready  <= !w_held_nxt;
      s_axil_arready <= !rvalid_nxt;
      reg_wr         <= wr_sel;
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= aw_ok ? 2'b00 : 2'b10;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      s_axil_rvalid <= rvalid_nxt;
      if (ar_hs) begin
        s_axil_rresp <= ar_ok ? 2'b00 : 2'b10;
        s_axil_rdata <= ar_ok ? rd_word : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (rst) begin
        regs[i] <= RESET_VALUE;
      end else if (wr_sel[i]) begin
        for (int unsigned k = 0; k < STRB_WIDTH; k++)
          if (w_strb[k]) regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: table of single writes with read-back,
// plus hand sequences for ordering, back-pressure, collision and reset cases.
module tb_axil_reg_bank;

  logic         clk, rst;
  logic [15:0]  awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr;

  int total = 0;
  int bad = 0;

  axil_reg_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .REG_COUNT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_out(reg_out), .reg_wr(reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [15:0] pulse;
    int          idx;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulses);
    int n = 0;
    logic aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    pulses = '0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick(); n++;
      pulses |= reg_wr;
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
    end
    bready = 1'b1;
    while (!bvalid && n < 50) begin
      tick(); n++;
      pulses |= reg_wr;
    end
    check("wr_timeout", n < 50, 1);
    resp = bresp;
    tick();
    pulses |= reg_wr;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin
      tick(); n++;
    end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin
      tick(); n++;
    end
    check("rd_timeout", n < 50, 1);
    d = rdata; r = rresp;
    tick();
    rready = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [15:0] pulses;
  logic [31:0] rd;

  initial begin
    vecs[0] = '{16'h0008, 32'hFFFFFFFF, 4'hF, 2'b00, 16'h0004, 2,  32'hFFFFFFFF};
    vecs[1] = '{16'h000C, 32'h12345678, 4'h3, 2'b00, 16'h0008, 3,  32'hA5A55678};
    vecs[2] = '{16'h000E, 32'hAABBCCDD, 4'hC, 2'b00, 16'h0008, 3,  32'hAABB5678};
    vecs[3] = '{16'h003C, 32'h0F0F0F0F, 4'h0, 2'b00, 16'h8000, 15, 32'h00000000};
    vecs[4] = '{16'h0040, 32'h55555555, 4'hF, 2'b10, 16'h0000, 0,  32'h00000000};
    vecs[5] = '{16'hFFFC, 32'h66666666, 4'hF, 2'b10, 16'h0000, 15, 32'h00000000};

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_awready", awready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    tick();
    check("ready_aw", awready, 1);
    check("ready_w", wready, 1);
    check("ready_ar", arready, 1);
    check("rst_reg0", rg(0), 32'h0);
    check("rst_regwr", reg_wr, 16'h0);

    // Aligned write, AW and W together
    awaddr = 16'h0004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_bvalid_early", bvalid, 0);
    check("t1_awready_low", awready, 0);
    tick();
    check("t1_bvalid", bvalid, 1);
    check("t1_bresp", bresp, 2'b00);
    check("t1_pulse", reg_wr, 16'h0002);
    check("t1_reg1", rg(1), 32'hDEADBEEF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("t1_bvalid_done", bvalid, 0);
    check("t1_pulse_done", reg_wr, 16'h0);
    check("t1_awready_back", awready, 1);
    do_read(16'h0004, rd, resp);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_rresp", resp, 2'b00);

    // Read and write of index 3 on the same edge: read sees the old value
    awaddr = 16'h000C; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 16'h000C; arvalid = 1'b1;
    check("t5_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check("t5_rvalid", rvalid, 1);
    check("t5_bvalid", bvalid, 1);
    check("t5_rdata_old", rdata, 32'h0);
    check("t5_reg3_new", rg(3), 32'hA5A5A5A5);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(16'h000C, rd, resp);
    check("t5_rdata_new", rd, 32'hA5A5A5A5);

    // Table of single writes with read-back
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulses);
      check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
      check($sformatf("v%0d_pulse", i), pulses, vecs[i].pulse);
      check($sformatf("v%0d_reg", i), rg(vecs[i].idx), vecs[i].val);
      do_read(vecs[i].addr, rd, resp);
      check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
      check($sformatf("v%0d_rdata", i), rd, (vecs[i].resp == 2'b00) ? vecs[i].val : 32'h0);
    end

    // W three cycles ahead of AW, partial strobe over 0xFFFFFFFF
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("t2_wready_low", wready, 0);
    check("t2_awready_high", awready, 1);
    tick(); tick();
    check("t2_no_b", bvalid, 0);
    awaddr = 16'h0008; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t2_bvalid_early", bvalid, 0);
    tick();
    check("t2_bvalid", bvalid, 1);
    check("t2_bresp", bresp, 2'b00);
    check("t2_reg2", rg(2), 32'hFF22FF44);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_single_b", bvalid, 0);
      tick();
    end

    // B back-pressure stalls a second write
    awaddr = 16'h0010; wdata = 32'h00001111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("t4_b1", bvalid, 1);
    awaddr = 16'h0014; wdata = 32'h00002222;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_awready_stall", awready, 0);
      check("t4_wready_stall", wready, 0);
      check("t4_b1_hold", {bvalid, bresp}, 3'b100);
      check("t4_reg5_stall", rg(5), 32'h0);
      tick();
    end
    bready = 1'b1;
    tick();
    check("t4_b2", bvalid, 1);
    check("t4_pulse2", reg_wr, 16'h0020);
    check("t4_reg5", rg(5), 32'h00002222);
    check("t4_reg4", rg(4), 32'h00001111);
    tick();
    bready = 1'b0;
    check("t4_b_done", bvalid, 0);

    // Reset with AW held and a read response pending
    awaddr = 16'h0000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    araddr = 16'h0008; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t6_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    tick(); tick();
    check("t6_bvalid", bvalid, 0);
    check("t6_rvalid", rvalid, 0);
    check("t6_rdata", rdata, 32'h0);
    check("t6_awready", awready, 0);
    for (int i = 0; i < 16; i++) check($sformatf("t6_reg%0d", i), rg(i), 32'h0);
    rst = 1'b0;
    check("t6_arready_first", arready, 0);
    tick();
    check("t6_awready_back", awready, 1);
    check("t6_wready_back", wready, 1);
    check("t6_arready_back", arready, 1);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_stray_b", bvalid, 0);
      check("t6_no_pulse", reg_wr, 16'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
AXI-Lite responder (slave) exposing a bank of REG_COUNT read/write registers to an AXI-Lite initiator, e.g. downstream of axil_adapter or an interconnect. Write and read channels are handled independently, with per-byte strobes and SLVERR on out-of-range addresses. Register contents and per-register write pulses are exported flat to fabric logic.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width; 32 or 64.
ADDR_WIDTH, 16, AXI-Lite address width.
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width; must equal DATA_WIDTH/8.
REG_COUNT, 16, number of registers; 1..256.
RESET_VALUE, 0, value loaded into every register on reset (DATA_WIDTH bits).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awprot  in  3  ignored
s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  STRB_WIDTH  byte enables
s_axil_wvalid / s_axil_wready  in / out  1  W handshake
s_axil_bresp  out  2  00 OKAY, 10 SLVERR
s_axil_bvalid / s_axil_bready  out / in  1  B handshake
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arprot  in  3  ignored
s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  00 OKAY, 10 SLVERR
s_axil_rvalid / s_axil_rready  out / in  1  R handshake
reg_out  out  REG_COUNT*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr  out  REG_COUNT  one-cycle pulse for register i on committed write

Behaviour:
- Reset (rst high at clk edge): aw_held=w_held=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg_wr=0, all registers=RESET_VALUE. awready/wready/arready are registered, 0 in the cycle after the reset edge and 1 from the first edge with rst low. Reset mid-transaction drops all in-flight state; no B/R response is issued for it.
- Decode: index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low address bits ignored. index < REG_COUNT -> OKAY; otherwise SLVERR.
- Write path: AW and W are accepted independently in any order into holding registers (aw_held, w_held). awready = !aw_held and wready = !w_held, both registered.
  - Commit edge: aw_held && w_held && (!bvalid || bready).
  - At commit, OKAY: byte k of register[index] <= wdata byte k where wstrb[k]=1; reg_wr[index]=1 for exactly the following cycle, also when wstrb=0.
  - At commit, SLVERR: no register change, no pulse.
  - At commit: bvalid<=1, bresp set, both holds cleared (readies return 1 the next cycle).
  - Latency: bvalid high one cycle after the later of the AW/W handshakes. Throughput: one write per 2 cycles.
  - bvalid stays high with bresp stable until bready. A pending B stalls the commit; holds and readies stay low.
- Read path: arready = !rvalid (registered).
  - On AR handshake at edge N, rdata/rresp are registered at edge N and rvalid is high after N.
  - OKAY: rdata = register[index] value before any write committing at the same edge (no bypass).
  - SLVERR: rdata = 0.
  - rvalid, rdata and rresp hold until the rready handshake. arready returns 1 the cycle after rvalid falls, so throughput is one read per 2 cycles.
- Read and write are fully concurrent; no arbitration. reg_out reflects register state combinationally from the registers.

Test Plan:
1. Reset then write addr 0x0004, wdata 0xDEADBEEF, wstrb 0xF, AW and W same cycle -> bvalid one cycle after handshake, bresp=00, reg_wr=0x0002 for one cycle, reg_out[63:32]=0xDEADBEEF; read 0x0004 -> rdata 0xDEADBEEF, rresp 00.
2. W issued 3 cycles before AW, addr 0x0008, wdata 0x11223344, wstrb 0x5, register previously 0xFFFFFFFF -> register = 0xFF22FF44, single B response OKAY.
3. Write to addr 0x0040 (index 16, REG_COUNT=16) -> bresp=10, no reg_wr pulse, reg_out unchanged; read 0x0040 -> rresp=10, rdata=0.
4. bready held low 5 cycles after a write, second AW/W presented -> second write not committed, awready/wready low, first bresp stable; on bready the second write commits and its B appears the next cycle.
5. Read and write to index 3 in the same commit edge (old value 0x0, new 0xA5A5A5A5) -> read returns 0x0; a subsequent read returns 0xA5A5A5A5.
6. rst asserted while AW held and rvalid high -> after reset bvalid=rvalid=0, all registers=RESET_VALUE, readies 1 from the second cycle after rst falls, no stray response.
